// File: rtl/sme_frame_loader.sv
// sme_frame_loader: buffers tagged string/pattern frames and replays them to the matching engine.
// Optional WAIT timeout enabled by defining SME_LOADER_TIMEOUT_EN.
module sme_frame_loader #(
  parameter int STR_MAX = 32,
`ifdef SME_LOADER_TIMEOUT_EN
  parameter int TIMEOUT = 64,
`endif
  parameter int PAT_MAX = 8
)(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [3:0] res_seq,
  output logic       res_err
);
  localparam int LW = $clog2(STR_MAX + 1);
  localparam int AW = $clog2(STR_MAX);
  typedef enum logic [2:0] {IDLE, LOAD, SEND_STR, SEND_PAT, WAIT} state_t;
  state_t state;
  logic [7:0] mem [STR_MAX];
  logic [LW-1:0] len, idx, cap;
  logic [3:0] seq;
  logic kind, str_loaded, str_trunc, pat_trunc, hs, k, fits;
`ifdef SME_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tcnt;
`endif
  assign hs = in_valid & in_ready;
  assign k = state == IDLE ? in_kind : kind;
  assign cap = k ? LW'(PAT_MAX) : LW'(STR_MAX);
  assign fits = state == IDLE || len < cap;
  always_ff @(posedge clk)
    if (hs && fits) mem[state == IDLE ? '0 : len[AW-1:0]] <= in_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      chardata <= '0;
      isstring <= 1'b0;
      ispattern <= 1'b0;
      res_valid <= 1'b0;
      res_match <= 1'b0;
      res_index <= '0;
      res_seq <= '0;
      res_err <= 1'b0;
      len <= '0;
      idx <= '0;
      seq <= '0;
      kind <= 1'b0;
      str_loaded <= 1'b0;
      str_trunc <= 1'b0;
      pat_trunc <= 1'b0;
`ifdef SME_LOADER_TIMEOUT_EN
      tcnt <= '0;
`endif
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          in_ready <= 1'b1;
          if (hs) begin
            state <= LOAD;
            if (state == IDLE) begin
              kind <= in_kind;
              len <= LW'(1);
              if (in_kind) pat_trunc <= 1'b0;
              else str_trunc <= 1'b0;
            end else if (fits) len <= len + 1'b1;
            else if (kind) pat_trunc <= 1'b1;
            else str_trunc <= 1'b1;
            // a pattern with no string behind it has nothing to match against
            if (in_last && k && !str_loaded) begin
              state <= IDLE;
              res_valid <= 1'b1;
              res_match <= 1'b0;
              res_index <= '0;
              res_err <= 1'b1;
              res_seq <= seq;
            end else if (in_last) begin
              state <= k ? SEND_PAT : SEND_STR;
              in_ready <= 1'b0;
              idx <= LW'(1);
              chardata <= state == IDLE ? in_data : mem[0];
              isstring <= !k;
              ispattern <= k;
            end
          end
        end
        SEND_STR, SEND_PAT: begin
          if (idx == len) begin
            isstring <= 1'b0;
            ispattern <= 1'b0;
            chardata <= '0;
            if (state == SEND_STR) begin
              state <= IDLE;
              in_ready <= 1'b1;
              str_loaded <= 1'b1;
              seq <= '0;
              res_seq <= '0;
            end else begin
              state <= WAIT;
`ifdef SME_LOADER_TIMEOUT_EN
              tcnt <= TW'(1);
`endif
            end
          end else begin
            chardata <= mem[idx[AW-1:0]];
            idx <= idx + 1'b1;
          end
        end
        WAIT: begin
          if (sme_valid) begin
            state <= IDLE;
            in_ready <= 1'b1;
            res_valid <= 1'b1;
            res_match <= sme_match;
            res_index <= sme_index;
            res_err <= str_trunc | pat_trunc;
            res_seq <= seq;
            seq <= seq + 4'd1;
          end
`ifdef SME_LOADER_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            state <= IDLE;
            in_ready <= 1'b1;
            res_valid <= 1'b1;
            res_match <= 1'b0;
            res_index <= '0;
            res_err <= 1'b1;
            res_seq <= seq;
            seq <= seq + 4'd1;
          end else tcnt <= tcnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sme_frame_loader.sv
// tb_sme_frame_loader: randomized frames checked against a frame-level model of the loader.
module tb_sme_frame_loader;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [7:0] in_data = '0;
  logic in_kind = 1'b0, in_last = 1'b0, in_valid = 1'b0, in_ready;
  logic [7:0] chardata;
  logic isstring, ispattern;
  logic sme_valid = 1'b0, sme_match = 1'b0;
  logic [4:0] sme_index = '0;
  logic res_valid, res_match, res_err;
  logic [4:0] res_index;
  logic [3:0] res_seq;
  int checks = 0, failures = 0;
  logic [7:0] fb [64];
  bit str_loaded_m = 1'b0, str_trunc_m = 1'b0;
  int seq_m = 0;
  string s;
  int first;

  sme_frame_loader dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_kind(in_kind), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
    .res_valid(res_valid), .res_match(res_match), .res_index(res_index), .res_seq(res_seq),
    .res_err(res_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
  endtask

  task automatic load_str(input string t);
    for (int i = 0; i < t.len(); i++) fb[i] = t[i];
  endtask

  // mode 0: back-to-back, 1: bubble every other cycle, 2: random bubbles
  task automatic drive_frame(input bit kind, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      if ((mode == 1 && i % 2 == 1) || (mode == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_kind = i == 0 ? kind : 1'($urandom);
      in_data = fb[i];
      in_last = i == n - 1;
      check("load_ready", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic check_strobes(input bit kind, input int n);
    int l;
    l = kind ? (n > 8 ? 8 : n) : (n > 32 ? 32 : n);
    for (int j = 0; j < l; j++) begin
      check(kind ? "ispattern" : "isstring", kind ? ispattern : isstring, 1);
      check("other_strobe", kind ? isstring : ispattern, 0);
      check("chardata", chardata, fb[j]);
      check("send_ready", in_ready, 0);
      sme_valid = 1'($urandom);
      sme_match = 1'($urandom);
      sme_index = 5'($urandom);
      @(negedge clk);
    end
    sme_valid = 1'b0;
    check("strobe_end", {isstring, ispattern}, 0);
    check("chardata_idle", chardata, 0);
  endtask

  task automatic run_frame(input bit kind, input int n, input int mode, input int dly,
                           input bit m, input logic [4:0] ix);
    drive_frame(kind, n, mode);
    if (kind && !str_loaded_m) begin
      check("drop_valid", res_valid, 1);
      check("drop_err", res_err, 1);
      check("drop_match", res_match, 0);
      check("drop_index", res_index, 0);
      check("drop_seq", res_seq, seq_m);
      check("drop_strobes", {isstring, ispattern}, 0);
      @(negedge clk);
      check("drop_pulse_end", res_valid, 0);
      check("drop_strobes2", {isstring, ispattern}, 0);
      return;
    end
    check_strobes(kind, n);
    if (!kind) begin
      check("str_ready_back", in_ready, 1);
      str_loaded_m = 1'b1;
      seq_m = 0;
      str_trunc_m = n > 32;
      return;
    end
    repeat (dly) begin
      check("wait_ready", in_ready, 0);
      check("wait_quiet", {res_valid, isstring, ispattern}, 0);
      @(negedge clk);
    end
    sme_valid = 1'b1;
    sme_match = m;
    sme_index = ix;
    @(negedge clk);
    sme_valid = 1'b0;
    sme_match = 1'($urandom);
    sme_index = 5'($urandom);
    check("res_valid", res_valid, 1);
    check("res_match", res_match, m);
    check("res_index", res_index, ix);
    check("res_seq", res_seq, seq_m);
    check("res_err", res_err, n > 8 || str_trunc_m);
    check("res_ready", in_ready, 1);
    seq_m = (seq_m + 1) % 16;
    @(negedge clk);
    check("res_pulse_end", res_valid, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_outs", {isstring, ispattern, chardata, res_valid, res_match, res_index, res_seq, res_err}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    fill(3);
    run_frame(1, 3, 0, 0, 1, 5);
    load_str("hello world");
    run_frame(0, 11, 0, 0, 0, 0);
    load_str("wor");
    run_frame(1, 3, 0, 4, 1, 6);
    fill(4);
    run_frame(1, 4, 0, 2, 0, 0);
    fill(6);
    run_frame(0, 6, 0, 0, 0, 0);
    fill(2);
    run_frame(1, 2, 0, 1, 1, 3);
    fill(35);
    run_frame(0, 35, 1, 0, 0, 0);
    fill(3);
    run_frame(1, 3, 0, 3, 1, 2);
    fill(5);
    run_frame(1, 5, 1, 0, 0, 0);
    fill(12);
    run_frame(0, 12, 0, 0, 0, 0);
    fill(10);
    run_frame(1, 10, 2, 5, 1, 9);
    for (int p = 0; p < 17; p++) begin
      fill(2);
      run_frame(1, 2, 0, 0, p[0], 5'(p));
    end
    repeat (40) begin
      bit kk;
      int n;
      kk = $urandom_range(0, 3) != 0;
      n = $urandom_range(1, kk ? 12 : 36);
      fill(n);
      run_frame(kk, n, $urandom_range(0, 2), $urandom_range(0, 20), 1'($urandom), 5'($urandom));
    end
    fill(4);
    drive_frame(1, 4, 0);
    check_strobes(1, 4);
    first = 0;
    for (int c = 1; c <= 1000 && first == 0; c++) begin
      if (res_valid) first = c;
      else @(negedge clk);
    end
`ifdef SME_LOADER_TIMEOUT_EN
    check("timeout_cycles", first, 64);
    check("timeout_err", res_err, 1);
    check("timeout_match", res_match, 0);
    check("timeout_seq", res_seq, seq_m);
`else
    check("no_timeout", first, 0);
`endif
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    str_loaded_m = 1'b0;
    seq_m = 0;
    str_trunc_m = 1'b0;
    fill(20);
    drive_frame(0, 20, 0);
    repeat (5) @(negedge clk);
    check("midsend_strobe", isstring, 1);
    reset_n = 1'b0;
    #1;
    check("rst_strobe_drop", {isstring, ispattern, chardata}, 0);
    check("rst_ready_drop", in_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst2", in_ready, 1);
    check("no_pulse_after_rst", res_valid, 0);
    fill(2);
    run_frame(1, 2, 0, 0, 0, 0);
    fill(7);
    run_frame(0, 7, 2, 0, 0, 0);
    fill(3);
    run_frame(1, 3, 0, 2, 1, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sme_frame_loader.md
# sme_frame_loader

Front-end stage for the string-matching engine: accepts a byte stream of tagged string/pattern frames over a valid/ready handshake, buffers each frame, and replays it as the engine's `isstring`/`ispattern`/`chardata` sequence. It waits for the engine's `valid` and returns each match result with a sequence tag. It sits between the host byte source and the matching engine.

## Interface
- `STR_MAX`, 32: string buffer depth in bytes (one engine string).
- `PAT_MAX`, 8: pattern buffer depth in bytes.
- `TIMEOUT`, 64: cycles to wait for `sme_valid` before aborting (only with the macro).
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  frame byte.
- `in_kind`  in  1  0 = string frame, 1 = pattern frame; sampled with every byte, meaningful on the first byte.
- `in_last`  in  1  last byte of frame.
- `in_valid`  in  1  byte present.
- `in_ready`  out  1  byte accepted when `in_valid & in_ready`.
- `chardata`  out  8  byte to engine.
- `isstring`  out  1  string byte strobe to engine.
- `ispattern`  out  1  pattern byte strobe to engine.
- `sme_valid`  in  1  engine result strobe.
- `sme_match`  in  1  engine match flag.
- `sme_index`  in  5  engine match index.
- `res_valid`  out  1  one-cycle result pulse.
- `res_match`  out  1  registered `sme_match`; 0 on timeout.
- `res_index`  out  5  registered `sme_index`; 0 on timeout.
- `res_seq`  out  4  pattern number since the last string, starting at 0.
- `res_err`  out  1  frame truncated, or timeout on this result.

## Operation
- FSM states: IDLE, LOAD, SEND_STR, SEND_PAT, WAIT.
- IDLE: `in_ready`=1. A handshake stores the byte at index 0, latches `in_kind` into `kind`, sets len=1, and moves to LOAD. If `in_last` is also set, it moves straight to the send state.
- LOAD: `in_ready`=1. Each handshake stores the byte at index len and increments len, saturating at STR_MAX or PAT_MAX for the current kind.
- Bytes past capacity are dropped and set sticky `trunc`.
- A handshake with `in_last` moves to SEND_STR (kind 0) or SEND_PAT (kind 1).
- Pattern frame with no string loaded since reset: it is fully consumed, then dropped. One result pulse with `res_err`=1, `res_match`=0, `res_index`=0, `res_seq` unchanged. Then return to IDLE.
- SEND_STR: drive `isstring`=1 and `chardata`=buf[i] for i=0..len-1 on consecutive cycles. Then clear `res_seq` and set `str_loaded`. Return to IDLE.
- SEND_PAT: drive `ispattern`=1 for len consecutive cycles, then go to WAIT.
- WAIT: `isstring`, `ispattern`, and `in_ready` are all 0. On `sme_valid`, register the result, pulse `res_valid` next cycle, and increment `res_seq` (4-bit wrap 15→0). Then go to IDLE.
- `res_err` on a normal result = `trunc` of that pattern or the current string. `trunc` clears when the next frame of the same kind starts.
- `chardata` is 0 whenever both strobes are low.
- `in_ready` is 0 in SEND_STR, SEND_PAT, and WAIT. It never depends combinationally on `in_valid`.
- `sme_valid` outside WAIT is ignored.
- Reset values: `in_ready`=0 during reset and 1 from the first cycle after release; all other outputs 0; FSM IDLE; `str_loaded`=0; `res_seq`=0.
- Reset mid-frame or mid-send aborts with no result pulse. The strobes drop immediately (asynchronous clear).

## Timing
- Last byte accepted at edge T → first strobe at T+1, last strobe at T+len.
- String: `in_ready` returns at T+len+1.
- Pattern: both strobes low from T+len+1 until `sme_valid`.
- `sme_valid` sampled at edge W → `res_valid` at W+1, `in_ready`=1 at W+1.
- Sustained one byte per cycle into LOAD, with no bubbles required.
- Strobes are contiguous, as the engine requires, regardless of input bubbles.

## Configuration
- `SME_LOADER_TIMEOUT_EN` defined: a counter in WAIT counts cycles. When TIMEOUT cycles elapse without `sme_valid`, emit `res_valid` with `res_match`=0, `res_index`=0, `res_err`=1, increment `res_seq`, and return to IDLE.
- Not defined: WAIT holds indefinitely and no counter is synthesized.

## Test plan
- String "hello world" (11 B) then pattern "wor" (3 B), engine model returns match=1 index=6 → `isstring` high 11 cycles, `ispattern` high 3 cycles, then `res_valid` with `res_match`=1, `res_index`=6, `res_seq`=0, `res_err`=0.
- Two patterns after one string, second returns match=0 → two pulses with `res_seq`=0 and 1; a new string resets the next `res_seq` to 0.
- 35-byte string frame → exactly 32 `isstring` cycles, bytes 32–34 dropped, next result has `res_err`=1.
- Pattern frame right after reset → no strobes, one pulse with `res_err`=1, `res_seq`=0.
- `in_valid` toggled every other cycle during a 5-byte pattern → `ispattern` still 5 contiguous cycles; `in_ready`=0 throughout WAIT.
- With `SME_LOADER_TIMEOUT_EN` and a silent engine → pulse exactly 64 cycles after the last `ispattern`, with `res_err`=1 and `res_match`=0. Without the macro, no pulse after 1000 cycles.
